// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter; bus_err exists only
// when ARB_TIMEOUT_EN is defined. slave = arbiter view, master = surrounding logic.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                d_ready;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
`ifdef ARB_TIMEOUT_EN
  logic                bus_err;
`endif

  modport slave (
`ifdef ARB_TIMEOUT_EN
    output bus_err,
`endif
    input  if_req, if_addr,
    output if_ready, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport master (
`ifdef ARB_TIMEOUT_EN
    input  bus_err,
`endif
    output if_req, if_addr,
    input  if_ready, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch waits and decides whether
// the data side may still win the next arbitration.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_d,
  input  logic grant_if,
  input  logic if_req,
  output logic allow_d
);
  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_d && if_req) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else if (grant_d || grant_if) begin
      starve_cnt <= 4'd0;
    end
  end

  assign allow_d = !if_req || (starve_cnt < CNT_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch and load/store requesters.
// Optional watchdog with bus_err pulse is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535 ||
      $bits(bus.mem_addr) != ADDR_W || $bits(bus.mem_rdata) != DATA_W) begin : g_bad_cfg
    $error("mem_port_arbiter: parameter out of range or interface width mismatch");
  end

  arb_state_t        state;
  owner_t            owner;
  logic              allow_d;
  logic              grant_d;
  logic              grant_if;
  logic              done;
  logic [DATA_W-1:0] done_data;

  // Readies are gated by reset so every output reads 0 while rst is low.
  assign grant_d     = rst && (state == IDLE) && bus.d_req && allow_d;
  assign grant_if    = rst && (state == IDLE) && bus.if_req && !grant_d;
  assign bus.d_ready  = grant_d;
  assign bus.if_ready = grant_if;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .grant_d (grant_d),
    .grant_if(grant_if),
    .if_req  (bus.if_req),
    .allow_d (allow_d)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd;
  logic        timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= 16'd0;
    end else if (state == IDLE) begin
      wd <= 16'd0;
    end else begin
      wd <= wd + 16'd1;
    end
  end
`endif

  // A same-cycle mem_ack takes precedence over watchdog expiry.
  always_comb begin
    done      = 1'b0;
    done_data = bus.mem_we ? {DATA_W{1'b0}} : bus.mem_rdata;
`ifdef ARB_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    if (state != IDLE) begin
      if (bus.mem_ack) begin
        done = 1'b1;
`ifdef ARB_TIMEOUT_EN
      end else if (wd == WD_LAST) begin
        done      = 1'b1;
        timed_out = 1'b1;
        done_data = {DATA_W{1'b0}};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_wstrb <= {(DATA_W/8){1'b0}};
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= {DATA_W{1'b0}};
`ifdef ARB_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
`endif
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= BUSY_D;
            owner         <= OWN_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : {(DATA_W/8){1'b0}};
          end else if (grant_if) begin
            state         <= BUSY_IF;
            owner         <= OWN_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_wstrb <= {(DATA_W/8){1'b0}};
          end
        end
        BUSY_IF, BUSY_D: begin
          if (done) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            bus.mem_req <= 1'b0;
            if (owner == OWN_IF) begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= done_data;
            end else begin
              bus.d_rvalid  <= 1'b1;
              bus.d_rdata   <= done_data;
            end
`ifdef ARB_TIMEOUT_EN
            bus.bus_err <= timed_out;
`endif
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end
endmodule
